// File: rtl/ram_2p_param.sv
// ram_2p_param: dual-port synchronous RAM with a power-up clear sequencer.
//
// After reset the controller writes zero to every word, one per cycle. Only
// when that sweep is finished does it raise ready and start accepting
// requests. Each port can read or write one word per cycle. Reads have one
// cycle of latency and pulse rvalidN when doutN updates.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | sweeping clr_addr over all words, writing zero; requests ignored
// ST_RUN   | memory initialised, ready = 1, port requests serviced
//
// Parameters
//   DATA_W      word width in bits
//   ADDR_W      address width; depth = 2**ADDR_W
//   RDW_MODE    cross-port read-during-write: 0 = old data, 1 = new data
//   DOUT1_LSB_W number of low read-data bits presented on dout1 (1..DATA_W)
//
// Ports
//   clk               single clock, rising edge
//   rst               synchronous active-high reset
//   en0/en1           per-port access request
//   we0/we1           1 = write, 0 = read (qualified by enN)
//   addr0/addr1       word address
//   din0/din1         write data
//   dout0/dout1       registered read data (dout1 zero-extended low bits)
//   rvalid0/rvalid1   one-cycle pulse when the matching dout updates
//   ready             clear finished, requests accepted
//   wcollide          one-cycle pulse after a same-address dual write

module ram_2p_param #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 7,
    parameter int RDW_MODE    = 0,
    parameter int DOUT1_LSB_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en0,
    input  logic              en1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    output logic [DATA_W-1:0] dout0,
    output logic [DATA_W-1:0] dout1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              ready,
    output logic              wcollide
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Keeps the low DOUT1_LSB_W bits; also handles DOUT1_LSB_W == DATA_W
    // without a zero-width concatenation.
    localparam logic [DATA_W-1:0] DOUT1_MASK = {DATA_W{1'b1}} >> (DATA_W - DOUT1_LSB_W);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
    logic [DATA_W-1:0]   r_dout0;
    logic [DATA_W-1:0]   r_dout1;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic                r_ready;
    logic                r_wcollide;

    logic                w_run;
    logic                w_wr0;
    logic                w_wr1;
    logic                w_rd0;
    logic                w_rd1;
    logic                w_same_addr;
    logic                w_collide;
    logic [DATA_W-1:0]   w_rdata0;
    logic [DATA_W-1:0]   w_rdata1;

    // A reset in RUN must abort the cycle's requests, so rst gates them here.
    assign w_run       = (r_state == ST_RUN) && !rst;
    assign w_wr0       = w_run && en0 && we0;
    assign w_wr1       = w_run && en1 && we1;
    assign w_rd0       = w_run && en0 && !we0;
    assign w_rd1       = w_run && en1 && !we1;
    assign w_same_addr = (addr0 == addr1);
    assign w_collide   = w_wr0 && w_wr1 && w_same_addr;

    // Cross-port bypass for new-data mode; old-data mode reads the array,
    // which still holds the pre-write word at this edge.
    assign w_rdata0 = ((RDW_MODE != 0) && w_wr1 && w_same_addr) ? din1 : r_mem[addr0];
    assign w_rdata1 = ((RDW_MODE != 0) && w_wr0 && w_same_addr) ? din0 : r_mem[addr1];

    // Memory array: not reset, it is swept to zero by the clear sequence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_addr] <= '0;
            end else begin
                // Port 0 wins a same-address dual write.
                if (w_wr1 && !w_collide) begin
                    r_mem[addr1] <= din1;
                end
                if (w_wr0) begin
                    r_mem[addr0] <= din0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_dout0    <= '0;
            r_dout1    <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_wcollide <= 1'b0;
            r_ready    <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_wcollide <= 1'b0;
            // Natural wrap back to 0 after the last word.
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
            if (&r_clr_addr) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
            end
        end else begin
            r_rvalid0  <= w_rd0;
            r_rvalid1  <= w_rd1;
            r_wcollide <= w_collide;
            if (w_rd0) begin
                r_dout0 <= w_rdata0;
            end
            if (w_rd1) begin
                r_dout1 <= w_rdata1 & DOUT1_MASK;
            end
        end
    end

    assign dout0    = r_dout0;
    assign dout1    = r_dout1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign ready    = r_ready;
    assign wcollide = r_wcollide;

endmodule

// File: doc/ram_2p_param.md
RAM_2P_PARAM -- requirements
Module: ram_2p_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 7, meaning address width; depth is fixed at 2**ADDR_W words.
REQ-003 SHALL provide parameter RDW_MODE, default 0, meaning cross-port read-during-write result: 0 = old data, 1 = new data.
REQ-004 SHALL provide parameter DOUT1_LSB_W, default 7, range 1..DATA_W, meaning number of low bits of port 1 read data passed to dout1; upper bits are zero.
REQ-005 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL provide port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL provide ports en0 and en1, input, 1 each, meaning per-port access request.
REQ-008 SHALL provide ports we0 and we1, input, 1 each, meaning write when 1 and read when 0; these are qualified by en.
REQ-009 SHALL provide ports addr0 and addr1, input, ADDR_W each, meaning word address.
REQ-010 SHALL provide ports din0 and din1, input, DATA_W each, meaning write data.
REQ-011 SHALL provide ports dout0 and dout1, output, DATA_W each, meaning registered read data.
REQ-012 SHALL provide ports rvalid0 and rvalid1, output, 1 each, meaning a one-cycle pulse when dout updates.
REQ-013 SHALL provide port ready, output, 1, meaning initialisation is complete and requests are accepted.
REQ-014 SHALL provide port wcollide, output, 1, meaning a one-cycle pulse on a same-address dual write.

Function
REQ-015 SHALL implement a 2-state FSM: CLEAR and RUN.
- CLEAR writes zero to mem[clr_addr] every cycle and increments clr_addr.
- CLEAR transitions to RUN in the cycle after clr_addr = 2**ADDR_W-1 is written.
- A full clear takes 2**ADDR_W cycles.
REQ-016 SHALL drive ready = 1 only in RUN.
REQ-017 SHALL ignore all en0/en1 requests while in CLEAR: no memory writes, rvalid stays 0, dout holds its value.
REQ-018 SHALL perform a write to mem[addrN] <= dinN at the clock edge when the FSM is in RUN, enN=1 and weN=1.
REQ-019 SHALL handle a read (RUN, enN=1, weN=0) as follows:
- doutN is loaded at the clock edge; read latency is 1 cycle.
- rvalidN = 1 for exactly that following cycle.
REQ-020 SHALL hold doutN at its last read value when no read is issued.
REQ-021 SHALL drive dout1 as the zero-extended low DOUT1_LSB_W bits of the word read; dout0 always carries the full word.
REQ-022 SHALL resolve a dual write to the same address with port 0's data, and pulse wcollide = 1 for one cycle after that edge.
REQ-023 SHALL store both words when both ports write different addresses, with no wcollide.
REQ-024 SHALL return, for a read on one port and a write on the other port to the same address in the same cycle:
- RDW_MODE=0: the pre-write word.
- RDW_MODE=1: the write data.
- The memory is updated in either mode.
REQ-025 SHALL allow both ports to read the same address in the same cycle, with both returning the identical word.
REQ-026 SHALL wrap clr_addr from 2**ADDR_W-1 to 0 without overflow side effects.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set:
- state = CLEAR, clr_addr = 0;
- dout0 = dout1 = 0;
- rvalid0 = rvalid1 = 0, wcollide = 0, ready = 0.
REQ-028 SHALL, for rst asserted during RUN, abort all requests in that cycle and re-clear the entire memory.
REQ-029 SHALL, for rst asserted during CLEAR, restart the clear from address 0.
REQ-030 SHALL leave memory contents unspecified while rst is held; all words read 0 after ready rises.

Verification
REQ-031 Bench SHALL check clear: deassert rst, then
- ready = 0 for 128 cycles and ready = 1 on cycle 129;
- reads of addresses 0, 64 and 127 return 0x0000 with rvalid pulsing.
REQ-032 Bench SHALL check write/read: port0 writes 0xBEEF to addr 5; port1 then reads addr 5 -> dout1 = 0x006F (low 7 bits); a port0 read of addr 5 -> dout0 = 0xBEEF; each result appears 1 cycle after the request.
REQ-033 Bench SHALL check collision: both ports write addr 9 (port0 0x1111, port1 0x2222) -> wcollide pulses 1 cycle and a later read of addr 9 returns 0x1111.
REQ-034 Bench SHALL check RDW: addr 3 holds 0xAAAA; port0 writes 0x5555 while port1 reads addr 3 -> dout1 = 0x002A with RDW_MODE=0, 0x0055 with RDW_MODE=1; a later read returns 0x5555 in both modes.
REQ-035 Bench SHALL check gating: requests issued during CLEAR -> no rvalid and no memory change; rst pulsed mid-RUN after writing 0x1234 to addr 0 -> ready drops, and after re-clear addr 0 reads 0x0000.
REQ-036 Bench SHALL check parametrisation: with DATA_W=32, ADDR_W=4, DOUT1_LSB_W=32 -> clear lasts 16 cycles and a write then read of 0xDEADBEEF on port1 returns 0xDEADBEEF.
